// File: rtl/cayde_pkg.sv
// Shared constants and decode types for the cayde decode/issue stage.
// ALU op codes match the encoding the downstream cayde ALU expects.
package cayde_pkg;

  localparam logic [6:0] ALU_ADD = 7'd0;
  localparam logic [6:0] ALU_SUB = 7'd1;
  localparam logic [6:0] ALU_XOR = 7'd2;
  localparam logic [6:0] ALU_AND = 7'd3;
  localparam logic [6:0] ALU_OR  = 7'd4;
  localparam logic [6:0] ALU_SLL = 7'd6;
  localparam logic [6:0] ALU_SRL = 7'd8;
  localparam logic [6:0] ALU_SRA = 7'd9;
  localparam logic [6:0] ALU_NOP = 7'd127;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    OPB_RS2   = 2'd0,
    OPB_IMM   = 2'd1,
    OPB_SHAMT = 2'd2
  } opb_sel_e;

  typedef struct packed {
    logic [6:0] alu_op;
    opb_sel_e   opb_sel;
    logic       use_rs1;
    logic       use_rs2;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/cayde_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, x0 never busy.
// Writeback and flush clears apply together; a same-cycle set of the same register wins.
module cayde_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              fclr_en,
  input  logic [REG_AW-1:0] fclr_addr,
  input  logic [REG_AW-1:0] look_a_addr,
  output logic              look_a_busy,
  input  logic [REG_AW-1:0] look_b_addr,
  output logic              look_b_busy
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en)  busy_nxt[clr_addr]  = 1'b0;
    if (fclr_en) busy_nxt[fclr_addr] = 1'b0;
    if (set_en)  busy_nxt[set_addr]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Lookups see the registered vector, so a register retiring this cycle still reads busy.
  assign look_a_busy = busy[look_a_addr];
  assign look_b_busy = busy[look_b_addr];

endmodule

// File: rtl/cayde_id_stage.sv
// Decode/issue stage feeding the cayde ALU: decodes RV32I OP/OP-IMM, checks
// operand hazards against the busy scoreboard, and holds one bundle for EX.
module cayde_id_stage
  import cayde_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_valid_i,
  input  logic [31:0]       instr_i,
  output logic              instr_ready_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [6:0]        alu_op_o,
  output logic [XLEN-1:0]   op_a_o,
  output logic [XLEN-1:0]   op_b_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              rd_we_o,
  output logic              illegal_o,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              flush_i
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rd_d;
  dec_t              dec;
  logic              rd_we_d;
  logic [XLEN-1:0]   op_a_d;
  logic [XLEN-1:0]   op_b_d;

  logic busy_rs1;
  logic busy_rs2;
  logic hazard;
  logic free;
  logic accept;

  logic              vld_p0;
  logic [6:0]        alu_op_p0;
  logic [XLEN-1:0]   op_a_p0;
  logic [XLEN-1:0]   op_b_p0;
  logic [REG_AW-1:0] rd_p0;
  logic              rd_we_p0;
  logic              illegal_p0;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rd_d       = instr_i[7 +: REG_AW];
  assign rs1_addr_o = instr_i[15 +: REG_AW];
  assign rs2_addr_o = instr_i[20 +: REG_AW];

  // Anything left at ALU_NOP after the opcode/funct match is an unsupported encoding.
  always_comb begin
    dec = '{alu_op: ALU_NOP, opb_sel: OPB_RS2, use_rs1: 1'b0, use_rs2: 1'b0, illegal: 1'b1};
    if (opcode == OPC_OP) begin
      case (funct3)
        F3_ADD: begin
          if (funct7 == F7_BASE)     dec.alu_op = ALU_ADD;
          else if (funct7 == F7_ALT) dec.alu_op = ALU_SUB;
        end
        F3_SLL: if (funct7 == F7_BASE) dec.alu_op = ALU_SLL;
        F3_XOR: if (funct7 == F7_BASE) dec.alu_op = ALU_XOR;
        F3_SR: begin
          if (funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
          else if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
        end
        F3_OR:  if (funct7 == F7_BASE) dec.alu_op = ALU_OR;
        F3_AND: if (funct7 == F7_BASE) dec.alu_op = ALU_AND;
        default: ;
      endcase
      dec.illegal = (dec.alu_op == ALU_NOP);
      dec.use_rs1 = !dec.illegal;
      dec.use_rs2 = !dec.illegal;
    end else if (opcode == OPC_OPIMM) begin
      // Only the shift-immediates carry a funct7; the rest use [31:25] as immediate bits.
      case (funct3)
        F3_ADD: begin dec.alu_op = ALU_ADD; dec.opb_sel = OPB_IMM; end
        F3_XOR: begin dec.alu_op = ALU_XOR; dec.opb_sel = OPB_IMM; end
        F3_OR:  begin dec.alu_op = ALU_OR;  dec.opb_sel = OPB_IMM; end
        F3_AND: begin dec.alu_op = ALU_AND; dec.opb_sel = OPB_IMM; end
        F3_SLL: begin
          if (funct7 == F7_BASE) dec.alu_op = ALU_SLL;
          dec.opb_sel = OPB_SHAMT;
        end
        F3_SR: begin
          if (funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
          else if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
          dec.opb_sel = OPB_SHAMT;
        end
        default: ;
      endcase
      dec.illegal = (dec.alu_op == ALU_NOP);
      dec.use_rs1 = !dec.illegal;
    end
  end

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    if (!dec.illegal) begin
      op_a_d = rs1_data_i;
      case (dec.opb_sel)
        OPB_IMM:   op_b_d = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        OPB_SHAMT: op_b_d = {{(XLEN-5){1'b0}}, instr_i[24:20]};
        default:   op_b_d = rs2_data_i;
      endcase
    end
  end

  assign rd_we_d       = !dec.illegal && (rd_d != '0);
  assign hazard        = (dec.use_rs1 && busy_rs1) || (dec.use_rs2 && busy_rs2);
  assign free          = !vld_p0 || ex_ready_i;
  assign instr_ready_o = free && !hazard && !flush_i;
  assign accept        = instr_valid_i && instr_ready_o;

  cayde_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .set_en      (accept && rd_we_d),
    .set_addr    (rd_d),
    .clr_en      (wb_valid_i),
    .clr_addr    (wb_rd_i),
    .fclr_en     (flush_i && vld_p0 && rd_we_p0),
    .fclr_addr   (rd_p0),
    .look_a_addr (rs1_addr_o),
    .look_a_busy (busy_rs1),
    .look_b_addr (rs2_addr_o),
    .look_b_busy (busy_rs2)
  );

  // Stage p0: single-entry issue register toward EX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0     <= 1'b0;
      alu_op_p0  <= '0;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      rd_p0      <= '0;
      rd_we_p0   <= 1'b0;
      illegal_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0     <= 1'b1;
      alu_op_p0  <= dec.alu_op;
      op_a_p0    <= op_a_d;
      op_b_p0    <= op_b_d;
      rd_p0      <= rd_d;
      rd_we_p0   <= rd_we_d;
      illegal_p0 <= dec.illegal;
    end else if (flush_i || ex_ready_i) begin
      vld_p0     <= 1'b0;
    end
  end

  assign ex_valid_o = vld_p0;
  assign alu_op_o   = alu_op_p0;
  assign op_a_o     = op_a_p0;
  assign op_b_o     = op_b_p0;
  assign rd_addr_o  = rd_p0;
  assign rd_we_o    = rd_we_p0;
  assign illegal_o  = illegal_p0;

endmodule

// File: tb/tb_cayde_id_stage.sv
// Bench for cayde_id_stage: table-driven decode vectors checked through an
// expected-bundle queue, plus hand sequences for stalls, backpressure, flush and reset.
module tb_cayde_id_stage;

  typedef struct packed {
    logic [6:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_ready_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b0;
  logic [6:0]  alu_op_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        illegal_o;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic        flush_i = 1'b0;

  int   total = 0;
  int   bad = 0;
  exp_t cur_exp;
  exp_t sb_q[$];
  exp_t got;
  vec_t vecs[23];

  always #5 clk = ~clk;

  cayde_id_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .alu_op_o      (alu_op_o),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .rd_addr_o     (rd_addr_o),
    .rd_we_o       (rd_we_o),
    .illegal_o     (illegal_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .flush_i       (flush_i)
  );

  assign got = '{alu_op: alu_op_o, op_a: op_a_o, op_b: op_b_o, rd: rd_addr_o,
                 rd_we: rd_we_o, illegal: illegal_o};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we, input logic ill);
    return '{alu_op: op, op_a: a, op_b: b, rd: rd, rd_we: we, illegal: ill};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Monitor: push on accept, pop on consume, discard on flush.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (ex_valid_o && flush_i) begin
        if (sb_q.size() == 0) check("flush_empty_queue", 80'd1, 80'd0);
        else void'(sb_q.pop_front());
      end else if (ex_valid_o && ex_ready_i) begin
        if (sb_q.size() == 0) check("unexpected_bundle", got, 80'd0);
        else check("bundle", got, sb_q.pop_front());
      end
      if (instr_valid_i && instr_ready_o) sb_q.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
    instr_i       = ins;
    rs1_data_i    = a;
    rs2_data_i    = b;
    cur_exp       = e;
    instr_valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!instr_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: instr %h never accepted", instr_i);
    end
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic accept_now();
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid_i = 1'b1;
    wb_rd_i    = r;
    tick();
    wb_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{itype(12'hFFB, 5'd0, 3'd0, 5'd1), 32'h0, 32'h55, mk(7'd0, 32'h0, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0)};
    vecs[1]  = '{rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd10, 32'd20, mk(7'd0, 32'd10, 32'd20, 5'd3, 1'b1, 1'b0)};
    vecs[2]  = '{rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, mk(7'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0)};
    vecs[3]  = '{rtype(7'h00, 5'd6, 5'd5, 3'd4, 5'd4), 32'hF0F0, 32'h0FF0, mk(7'd2, 32'hF0F0, 32'h0FF0, 5'd4, 1'b1, 1'b0)};
    vecs[4]  = '{rtype(7'h00, 5'd6, 5'd5, 3'd7, 5'd4), 32'h1111, 32'h2222, mk(7'd3, 32'h1111, 32'h2222, 5'd4, 1'b1, 1'b0)};
    vecs[5]  = '{rtype(7'h00, 5'd6, 5'd5, 3'd6, 5'd4), 32'h3333, 32'h4444, mk(7'd4, 32'h3333, 32'h4444, 5'd4, 1'b1, 1'b0)};
    vecs[6]  = '{rtype(7'h00, 5'd6, 5'd5, 3'd1, 5'd4), 32'h5, 32'h6, mk(7'd6, 32'h5, 32'h6, 5'd4, 1'b1, 1'b0)};
    vecs[7]  = '{rtype(7'h00, 5'd6, 5'd5, 3'd5, 5'd4), 32'h7, 32'h8, mk(7'd8, 32'h7, 32'h8, 5'd4, 1'b1, 1'b0)};
    vecs[8]  = '{rtype(7'h20, 5'd6, 5'd5, 3'd5, 5'd4), 32'h9, 32'hA, mk(7'd9, 32'h9, 32'hA, 5'd4, 1'b1, 1'b0)};
    vecs[9]  = '{itype(12'h7FF, 5'd8, 3'd6, 5'd7), 32'h1000, 32'hDEAD, mk(7'd4, 32'h1000, 32'h7FF, 5'd7, 1'b1, 1'b0)};
    vecs[10] = '{itype(12'h800, 5'd8, 3'd7, 5'd7), 32'h1001, 32'hDEAD, mk(7'd3, 32'h1001, 32'hFFFFF800, 5'd7, 1'b1, 1'b0)};
    vecs[11] = '{itype(12'hABC, 5'd8, 3'd4, 5'd7), 32'h1002, 32'hDEAD, mk(7'd2, 32'h1002, 32'hFFFFFABC, 5'd7, 1'b1, 1'b0)};
    vecs[12] = '{itype({7'h00, 5'd31}, 5'd10, 3'd1, 5'd9), 32'h3, 32'hBEEF, mk(7'd6, 32'h3, 32'd31, 5'd9, 1'b1, 1'b0)};
    vecs[13] = '{32'h4032D293, 32'hF0000000, 32'h1234, mk(7'd9, 32'hF0000000, 32'd3, 5'd5, 1'b1, 1'b0)};
    vecs[14] = '{itype({7'h00, 5'd7}, 5'd10, 3'd5, 5'd9), 32'h80, 32'hBEEF, mk(7'd8, 32'h80, 32'd7, 5'd9, 1'b1, 1'b0)};
    vecs[15] = '{rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd1, 32'd2, mk(7'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0)};
    vecs[16] = '{32'h003120B3, 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1)};
    vecs[17] = '{rtype(7'h20, 5'd6, 5'd5, 3'd4, 5'd4), 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1)};
    vecs[18] = '{itype({7'h20, 5'd1}, 5'd10, 3'd1, 5'd9), 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1)};
    vecs[19] = '{32'h000010B7, 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1)};
    vecs[20] = '{itype(12'h005, 5'd8, 3'd3, 5'd7), 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1)};
    vecs[21] = '{rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'h99, 32'h77, mk(7'd127, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1)};
    vecs[22] = '{itype(12'hFFF, 5'd0, 3'd0, 5'd0), 32'h0, 32'h77, mk(7'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {ex_valid_o, got}, 80'd0);
    tick();
    rst_ni     = 1'b1;
    ex_ready_i = 1'b1;
    tick();

    foreach (vecs[i]) begin
      present(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].exp);
      #1;
      check("rs_addr", {rs1_addr_o, rs2_addr_o}, {vecs[i].instr[19:15], vecs[i].instr[24:20]});
      wait_accept();
      retire(vecs[i].exp.rd);
    end

    // RAW stall on x2 until the cycle after its writeback.
    present(itype(12'd1, 5'd0, 3'd0, 5'd2), 32'h0, 32'h0, mk(7'd0, 32'h0, 32'd1, 5'd2, 1'b1, 1'b0));
    wait_accept();
    present(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd50, 32'd8, mk(7'd1, 32'd50, 32'd8, 5'd3, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hazard_stall", instr_ready_o, 1'b0);
    end
    @(posedge clk); #1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd2;
    @(negedge clk);
    check("stall_during_wb", instr_ready_o, 1'b0);
    @(posedge clk); #1;
    wb_valid_i = 1'b0;
    @(negedge clk);
    check("ready_after_wb", instr_ready_o, 1'b1);
    accept_now();
    retire(5'd3);

    // Backpressure: bundle held stable for three cycles.
    ex_ready_i = 1'b0;
    present(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 32'd3, 32'd4, mk(7'd0, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0));
    wait_accept();
    present(rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd6), 32'd1, 32'd2, mk(7'd2, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_valid", ex_valid_o, 1'b1);
      check("held_bundle", got, mk(7'd0, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0));
      check("held_ready", instr_ready_o, 1'b0);
    end
    @(posedge clk); #1;
    ex_ready_i = 1'b1;
    wait_accept();
    retire(5'd4);
    retire(5'd6);

    // Illegal SLT leaves the scoreboard alone.
    present(32'h003120B3, 32'h9, 32'h9, mk(7'd127, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
    wait_accept();
    present(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd6), 32'd11, 32'd0, mk(7'd0, 32'd11, 32'd0, 5'd6, 1'b1, 1'b0));
    @(negedge clk);
    check("slt_no_busy", instr_ready_o, 1'b1);
    accept_now();
    retire(5'd6);

    // Flush of a held SRAI together with a writeback of x7.
    present(itype(12'd1, 5'd0, 3'd0, 5'd7), 32'h0, 32'h0, mk(7'd0, 32'h0, 32'd1, 5'd7, 1'b1, 1'b0));
    wait_accept();
    tick();
    ex_ready_i = 1'b0;
    present(32'h4032D293, 32'h80000000, 32'h0, mk(7'd9, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0));
    wait_accept();
    present(rtype(7'h00, 5'd7, 5'd5, 3'd0, 5'd6), 32'h11, 32'h22, mk(7'd0, 32'h11, 32'h22, 5'd6, 1'b1, 1'b0));
    flush_i    = 1'b1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd7;
    @(negedge clk);
    check("flush_blocks_accept", instr_ready_o, 1'b0);
    @(posedge clk); #1;
    flush_i    = 1'b0;
    wb_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    check("flush_clears_valid", ex_valid_o, 1'b0);
    check("flush_frees_x5_x7", instr_ready_o, 1'b1);
    accept_now();
    retire(5'd6);

    // Same-cycle set and writeback of x4: set wins.
    present(itype(12'd9, 5'd0, 3'd0, 5'd4), 32'h0, 32'h0, mk(7'd0, 32'h0, 32'd9, 5'd4, 1'b1, 1'b0));
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd4;
    wait_accept();
    wb_valid_i = 1'b0;
    present(rtype(7'h00, 5'd0, 5'd4, 3'd0, 5'd6), 32'd9, 32'd0, mk(7'd0, 32'd9, 32'd0, 5'd6, 1'b1, 1'b0));
    @(negedge clk);
    check("set_wins", instr_ready_o, 1'b0);
    @(posedge clk); #1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd4;
    @(negedge clk);
    check("set_wins_wb_cycle", instr_ready_o, 1'b0);
    @(posedge clk); #1;
    wb_valid_i = 1'b0;
    wait_accept();
    retire(5'd6);

    // Asynchronous reset with a bundle held and x8 busy.
    ex_ready_i = 1'b0;
    present(itype(12'd2, 5'd0, 3'd0, 5'd8), 32'h0, 32'h0, mk(7'd0, 32'h0, 32'd2, 5'd8, 1'b1, 1'b0));
    wait_accept();
    #3;
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_valid", ex_valid_o, 1'b0);
    check("async_reset_bundle", got, 80'd0);
    @(posedge clk); #1;
    rst_ni     = 1'b1;
    ex_ready_i = 1'b1;
    present(rtype(7'h00, 5'd0, 5'd8, 3'd0, 5'd6), 32'h5, 32'h0, mk(7'd0, 32'h5, 32'h0, 5'd6, 1'b1, 1'b0));
    @(negedge clk);
    check("reset_clears_busy", instr_ready_o, 1'b1);
    accept_now();
    retire(5'd6);

    repeat (3) tick();
    check("queue_drained", sb_q.size(), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
